// File: rtl/serial_tx_if.sv
// serial_tx_if: bundles the producer handshake and the serial-side outputs of
// serial_tx_shifter.
//   master: the producer/observer side (drives load_data/load_valid)
//   slave : the transmitter side (drives load_ready, tx_d, busy, done)
// Signals:
//   load_data  [DATA_W] word to transmit, sampled on an accepted load
//   load_valid          producer has a word on load_data
//   load_ready          transmitter can accept a word this cycle
//   tx_d                serial line, idles high
//   busy                frame in progress
//   done                one-cycle pulse on the last cycle of the stop bit
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic              tx_d;
    logic              busy;
    logic              done;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  tx_d,
        input  busy,
        input  done
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output tx_d,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter: parallel-load, serial-out frame transmitter.
// Latches a word on a valid/ready handshake and shifts it out LSB-first as
// start bit (0), DATA_W data bits, optional even-parity bit, stop bit (1).
// Every serial bit is held for BIT_CYCLES clocks.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset; aborts any frame, line goes high
//   tx_bus  serial_tx_if.slave (load_data/load_valid/load_ready/tx_d/busy/done)
//
// Build option:
//   SERIAL_TX_PARITY_EN  when defined, a PARITY bit (XOR of the latched word)
//                        is sent between the last data bit and the stop bit.
//
// State table:
//   state    | meaning
//   S_IDLE   | line high, load_ready=1, waiting for load_valid
//   S_START  | start bit (0) on tx_d
//   S_DATA   | data bit shreg_q[0] on tx_d, bit_q = index of current bit
//   S_PARITY | even-parity bit on tx_d (SERIAL_TX_PARITY_EN only)
//   S_STOP   | stop bit (1) on tx_d, done on its last cycle
module serial_tx_shifter #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    serial_tx_if.slave tx_bus
);

    localparam int CW = ($clog2(BIT_CYCLES + 1) < 1) ? 1 : $clog2(BIT_CYCLES + 1);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    // done is registered, so it is armed one count before the final stop cycle
    localparam int DONE_ARM = BIT_CYCLES - 2;
    localparam logic DONE_ON_ENTRY = (BIT_CYCLES == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [BW-1:0]     bit_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q;
`endif

    assign bit_end = (cnt_q == CNT_LAST);
    assign cnt_d   = cnt_q + 1'b1;
    assign shreg_d = shreg_q >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    bit_q  <= '0;
                    if (tx_bus.load_valid) begin
                        shreg_q  <= tx_bus.load_data;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q <= ^tx_bus.load_data;
`endif
                        state_q  <= S_START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                            done_q  <= DONE_ON_ENTRY;
`endif
                        end else begin
                            shreg_q <= shreg_d;
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shreg_d[0];
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state_q <= S_STOP;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        done_q  <= DONE_ON_ENTRY;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_d;
                        done_q <= (int'(cnt_q) == DONE_ARM);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_bus.load_ready = (state_q == S_IDLE);
    assign tx_bus.tx_d       = tx_q;
    assign tx_bus.busy       = busy_q;
    assign tx_bus.done       = done_q;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// tb_serial_tx_shifter: self-checking bench for serial_tx_shifter.
// dut_a runs the default geometry (8 data bits, 4 clocks per bit); dut_b runs
// 4 data bits at 1 clock per bit. Expected line values come from a frame model:
// the list of serial bits (start, data LSB-first, optional parity, stop) with
// bit n covering clocks n*BIT_CYCLES+1 .. (n+1)*BIT_CYCLES after the accept edge.
module tb_serial_tx_shifter;

    localparam int DW  = 8;
    localparam int BC  = 4;
    localparam int DW2 = 4;
    localparam int BC2 = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LEN  = (DW + 2 + PB) * BC;
    localparam int LEN2 = (DW2 + 2 + PB) * BC2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_tx_if #(.DATA_W(DW))  bus_a ();
    serial_tx_if #(.DATA_W(DW2)) bus_b ();

    serial_tx_shifter #(.DATA_W(DW), .BIT_CYCLES(BC)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .tx_bus (bus_a)
    );

    serial_tx_shifter #(.DATA_W(DW2), .BIT_CYCLES(BC2)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .tx_bus (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // serial bit number idx of the frame carrying word w (dw data bits)
    function automatic logic exp_bit(input logic [31:0] w, input int dw, input int idx);
        logic p;
        if (idx == 0) return 1'b0;
        if (idx <= dw) return w[idx-1];
        if (PB == 1 && idx == dw + 1) begin
            p = 1'b0;
            for (int i = 0; i < dw; i++) p = p ^ w[i];
            return p;
        end
        return 1'b1;
    endfunction

    task automatic accept_a(input logic [7:0] w, input bit keep_valid);
        @(negedge clk);
        bus_a.load_data  = w;
        bus_a.load_valid = 1'b1;
        chk("a_ready_before_accept", bus_a.load_ready, 1);
        @(posedge clk);
        #1;
        if (!keep_valid) bus_a.load_valid = 1'b0;
    endtask

    task automatic frame_a(input logic [7:0] w, input bit disturb);
        for (int k = 1; k <= LEN; k++) begin
            @(negedge clk);
            chk("a_tx",    bus_a.tx_d,       exp_bit(w, DW, (k - 1) / BC));
            chk("a_busy",  bus_a.busy,       1);
            chk("a_done",  bus_a.done,       (k == LEN));
            chk("a_ready", bus_a.load_ready, 0);
            if (disturb && k == 10) begin
                bus_a.load_data  = 8'h00;
                bus_a.load_valid = 1'b1;
            end
            if (disturb && k == 12) bus_a.load_valid = 1'b0;
        end
    endtask

    task automatic idle_a();
        @(negedge clk);
        chk("a_idle_tx",    bus_a.tx_d,       1);
        chk("a_idle_busy",  bus_a.busy,       0);
        chk("a_idle_done",  bus_a.done,       0);
        chk("a_idle_ready", bus_a.load_ready, 1);
    endtask

    task automatic run_b(input logic [3:0] w);
        @(negedge clk);
        bus_b.load_data  = w;
        bus_b.load_valid = 1'b1;
        chk("b_ready_before_accept", bus_b.load_ready, 1);
        @(posedge clk);
        #1;
        bus_b.load_valid = 1'b0;
        for (int k = 1; k <= LEN2; k++) begin
            @(negedge clk);
            chk("b_tx",    bus_b.tx_d,       exp_bit(w, DW2, (k - 1) / BC2));
            chk("b_busy",  bus_b.busy,       1);
            chk("b_done",  bus_b.done,       (k == LEN2));
            chk("b_ready", bus_b.load_ready, 0);
        end
        @(negedge clk);
        chk("b_idle_tx",    bus_b.tx_d,       1);
        chk("b_idle_busy",  bus_b.busy,       0);
        chk("b_idle_ready", bus_b.load_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic [3:0] wb;

        rst_n            = 1'b1;
        bus_a.load_data  = '0;
        bus_a.load_valid = 1'b0;
        bus_b.load_data  = '0;
        bus_b.load_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        // reset values, before any clock edge
        chk("rst_tx",    bus_a.tx_d,       1);
        chk("rst_busy",  bus_a.busy,       0);
        chk("rst_done",  bus_a.done,       0);
        chk("rst_ready", bus_a.load_ready, 1);
        chk("rst_b_tx",  bus_b.tx_d,       1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed 0xA5 frame
        accept_a(8'hA5, 1'b0);
        frame_a(8'hA5, 1'b0);
        idle_a();

        // back-to-back with load_valid held: exactly one idle cycle between frames
        accept_a(8'h01, 1'b1);
        bus_a.load_data = 8'hFF;
        frame_a(8'h01, 1'b0);
        idle_a();
        @(posedge clk);
        #1;
        bus_a.load_valid = 1'b0;
        frame_a(8'hFF, 1'b0);
        idle_a();

        // load attempt while busy must be ignored
        accept_a(8'h3C, 1'b0);
        frame_a(8'h3C, 1'b1);
        idle_a();
        idle_a();

        // parity-relevant words, then random words
        accept_a(8'h07, 1'b0);
        frame_a(8'h07, 1'b0);
        idle_a();
        accept_a(8'h03, 1'b0);
        frame_a(8'h03, 1'b0);
        idle_a();
        repeat (4) begin
            w = 8'($urandom);
            accept_a(w, 1'b0);
            frame_a(w, 1'b0);
            idle_a();
        end

        // asynchronous reset in the middle of data bit 3 of 0x55
        accept_a(8'h55, 1'b0);
        repeat (18) @(negedge clk);
        chk("pre_rst_tx", bus_a.tx_d, exp_bit(8'h55, DW, 4));
        chk("pre_rst_busy", bus_a.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx",    bus_a.tx_d,       1);
        chk("midrst_busy",  bus_a.busy,       0);
        chk("midrst_ready", bus_a.load_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("post_rst_done",  bus_a.done,       0);
            chk("post_rst_tx",    bus_a.tx_d,       1);
            chk("post_rst_ready", bus_a.load_ready, 1);
        end

        // one-clock-per-bit instance
        run_b(4'h9);
        repeat (3) begin
            wb = 4'($urandom_range(0, 15));
            run_b(wb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
Parallel-load, serial-out frame transmitter. It is the driving end of the team's serial bit link: it latches a data word and shifts it out LSB-first on one line as a framed sequence (start bit, data bits, stop bit). The line is sampled at the far end by a D-flip-flop capture chain. It sits between a parallel producer (valid/ready handshake) and the single-wire serial output.

Parameters:
DATA_W, 8, data bits per frame; legal range 1..32
BIT_CYCLES, 4, clock cycles each serial bit is held on tx_d; legal range 1..255

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
load_data  input  DATA_W  word to transmit; sampled only on an accepted load
load_valid  input  1  producer has a word on load_data
load_ready  output  1  block can accept a word this cycle
tx_d  output  1  serial line; idles high
busy  output  1  frame in progress
done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect without a clock edge):
  - tx_d=1, busy=0, done=0, load_ready=1.
  - State IDLE; shift register, bit counter and cycle counter all cleared.
- Reset mid-frame: the frame is aborted immediately and the line returns high. There is no partial stop bit. After release the block is in IDLE.
- State machine states: IDLE, START, DATA, STOP. All outputs except load_ready are registered.
- load_ready = (state==IDLE), combinational from state.
- Accept: load_valid=1 and load_ready=1 at a rising edge.
  - load_data is latched into the shift register and the state goes to START.
  - From the next cycle, load_data is ignored until the next accept.
  - load_valid while busy is ignored; no word is lost or queued, and the producer holds it.
- START: tx_d=0 for BIT_CYCLES cycles, then go to DATA.
- DATA:
  - tx_d = shreg[0] for BIT_CYCLES cycles per bit. The register shifts right after each bit.
  - The bit counter counts 0..DATA_W-1. After bit DATA_W-1 completes, go to STOP.
- STOP:
  - tx_d=1 for BIT_CYCLES cycles.
  - done=1 during the final cycle of STOP only.
  - Then go to IDLE, with load_ready=1 in the following cycle.
- busy=1 from the cycle after accept through the last STOP cycle inclusive.
- Latency:
  - First start-bit cycle appears on tx_d one cycle after accept.
  - Frame length = (DATA_W+2)*BIT_CYCLES cycles.
- Back-to-back frames: if load_valid is held high, the next accept occurs on the first IDLE cycle. There is exactly one idle-high cycle between frames.
- Cycle counter width: ceil(log2(BIT_CYCLES+1)), minimum 1. It reloads to 0 at every bit boundary. BIT_CYCLES=1 gives one bit per clock with no extra idle.
- Counters never wrap outside their defined ranges; an illegal state recovers to IDLE with tx_d=1.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- When defined:
  - A parity bit is inserted between the last data bit and the stop bit.
  - Parity is even: tx_d = XOR of all DATA_W latched bits, held for BIT_CYCLES cycles in a PARITY state.
  - Frame length becomes (DATA_W+3)*BIT_CYCLES.
- When undefined: there is no PARITY state, no parity logic is synthesized, and the frame is as described above.

Test Plan:
1. Defaults, reset then load 0xA5 -> tx_d holds each bit for 4 cycles in order 0 (start), 1,0,1,0,0,1,0,1, then 1 (stop). done pulses exactly at cycle 40 after accept, and busy is high for 40 cycles.
2. Hold load_valid=1 with 0x01 then 0xFF -> two frames separated by exactly one idle-high cycle. Second frame data bits are all 1. load_ready is high for one cycle between the frames.
3. Change load_data to 0x00 and pulse load_valid during the 0x3C frame -> the transmitted frame is still 0x3C, the pulse is not accepted, and load_ready stays 0.
4. Assert rst_n=0 mid-data-bit 3 of frame 0x55 -> tx_d=1 and busy=0 without waiting for a clock edge. After release, load_ready=1 and no done pulse occurs.
5. BIT_CYCLES=1, DATA_W=4, load 0x9 -> tx_d sequence 0,1,0,0,1,1 on consecutive cycles, with done on the 6th cycle.
6. SERIAL_TX_PARITY_EN defined, load 0x07 -> parity bit 1 after the data bits. Load 0x03 -> parity bit 0. Frame length is 44 cycles at defaults.
